ibex_register_file_mp: RTL and testbench

// Flip-flop RISC-V integer register file with a parametrised number of read ports, two write

---
 rtl/ibex_register_file_mp.sv | 157 +++++++++++++++
 tb/tb_ibex_register_file_mp.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_register_file_mp.sv
// Flip-flop RISC-V register file: N combinational read ports, ALU (A) and load (B) write ports,
// per-register load-pending scoreboard and a one-register-per-cycle clear engine.
module ibex_register_file_mp #(
    parameter bit          RV32E        = 1'b0,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned NumReadPorts = 2,
    parameter bit          WriteForward = 1'b1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumReadPorts*5-1:0]         raddr_i,
    output logic [NumReadPorts*DataWidth-1:0] rdata_o,
    output logic [NumReadPorts-1:0]           rbusy_o,
    input  logic [4:0]                        waddr_a_i,
    input  logic [DataWidth-1:0]              wdata_a_i,
    input  logic                              we_a_i,
    input  logic [4:0]                        waddr_b_i,
    input  logic [DataWidth-1:0]              wdata_b_i,
    input  logic                              we_b_i,
    input  logic                              pend_set_i,
    input  logic [4:0]                        pend_addr_i,
    input  logic                              clear_req_i,
    output logic                              clear_busy_o
);

    localparam int unsigned AddrWidth = RV32E ? 4 : 5;
    localparam int unsigned NumWords  = 2 ** AddrWidth;

    typedef enum logic {
        ClrIdle,
        ClrActive
    } clr_state_e;

    clr_state_e                         state_q;
    logic [AddrWidth-1:0]               clr_idx_q;
    logic                               clr_busy_q;
    logic [NumWords-1:0][DataWidth-1:0] rf_q, rf_d;
    logic [NumWords-1:0]                pend_q, pend_d;

    logic                 idle, clr_start;
    logic                 we_a, we_b, wr_b, pend_set;
    logic [AddrWidth-1:0] wa, wb, pa;

    // x0 is hardwired; under RV32E the upper half of the address space does not exist.
    function automatic logic addr_valid(input logic [4:0] addr);
        addr_valid = (addr != 5'd0) && (!RV32E || !addr[4]);
    endfunction

    assign idle      = (state_q == ClrIdle);
    assign clr_start = idle && clear_req_i;

    assign wa = waddr_a_i[AddrWidth-1:0];
    assign wb = waddr_b_i[AddrWidth-1:0];
    assign pa = pend_addr_i[AddrWidth-1:0];

    assign we_a     = idle && we_a_i && addr_valid(waddr_a_i);
    assign we_b     = idle && we_b_i && addr_valid(waddr_b_i);
    assign pend_set = idle && pend_set_i && addr_valid(pend_addr_i);
    // Port A carries the younger instruction, so it shadows a load writeback to the same register.
    assign wr_b     = we_b && !(we_a && (wa == wb));

    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so the
    // later, higher-priority assignments override cleanly and no latch is inferred.
    always_comb begin
        rf_d = rf_q;
        if (!idle) begin
            rf_d[clr_idx_q] = '0;
        end else begin
            if (wr_b) rf_d[wb] = wdata_b_i;
            if (we_a) rf_d[wa] = wdata_a_i;
        end
        rf_d[0] = '0;
    end

    always_comb begin
        pend_d = pend_q;
        if (clr_start) begin
            pend_d = '0;
        end else begin
            if (we_b)     pend_d[wb] = 1'b0;
            if (pend_set) pend_d[pa] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // NOTE: the storage is plain flip-flops rather than an SRAM macro, so it can and must be
    // reset; sequential state is updated with non-blocking '<=' only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_q   <= '0;
            pend_q <= '0;
        end else begin
            rf_q   <= rf_d;
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ClrIdle;
            clr_idx_q  <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            case (state_q)
                ClrIdle: begin
                    if (clear_req_i) begin
                        state_q    <= ClrActive;
                        clr_idx_q  <= AddrWidth'(1);
                        clr_busy_q <= 1'b1;
                    end
                end
                ClrActive: begin
                    if (clr_idx_q == AddrWidth'(NumWords - 1)) begin
                        state_q    <= ClrIdle;
                        clr_busy_q <= 1'b0;
                    end else begin
                        clr_idx_q <= clr_idx_q + AddrWidth'(1);
                    end
                end
                default: begin
                    state_q    <= ClrIdle;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign clear_busy_o = clr_busy_q;

    for (genvar p = 0; p < NumReadPorts; p++) begin : g_rd
        logic [4:0]           ra;
        logic [AddrWidth-1:0] ri;
        logic [DataWidth-1:0] data;
        logic                 busy;

        assign ra = raddr_i[5*p +: 5];
        assign ri = ra[AddrWidth-1:0];

        always_comb begin
            data = '0;
            busy = 1'b0;
            if (addr_valid(ra)) begin
                data = rf_q[ri];
                busy = pend_q[ri];
                if (WriteForward) begin
                    if (we_a && (wa == ri))      data = wdata_a_i;
                    else if (wr_b && (wb == ri)) data = wdata_b_i;
                    if (we_b && (wb == ri))      busy = 1'b0;
                end
            end
        end

        assign rdata_o[DataWidth*p +: DataWidth] = data;
        assign rbusy_o[p]                        = busy;
    end

endmodule

// File: tb/tb_ibex_register_file_mp.sv
// Directed bench for ibex_register_file_mp: stimulus queues expected read values, a negedge
// monitor drains the queue and compares against the two DUT configurations (RV32I and RV32E).
module tb_ibex_register_file_mp;

    localparam int DW  = 32;
    localparam int NP  = 3;
    localparam int NPE = 2;

    logic clk_i = 1'b0;
    logic rst_ni;

    logic [NP*5-1:0]  raddr;
    logic [NP*DW-1:0] rdata;
    logic [NP-1:0]    rbusy;
    logic [4:0]       waddr_a, waddr_b, pend_addr;
    logic [DW-1:0]    wdata_a, wdata_b;
    logic             we_a, we_b, pend_set, clear_req, clear_busy;

    logic [NPE*5-1:0]  e_raddr;
    logic [NPE*DW-1:0] e_rdata;
    logic [NPE-1:0]    e_rbusy;
    logic [4:0]        e_waddr_a, e_waddr_b, e_pend_addr;
    logic [DW-1:0]     e_wdata_a, e_wdata_b;
    logic              e_we_a, e_we_b, e_pend_set, e_clear_req, e_clear_busy;

    ibex_register_file_mp #(
        .RV32E(1'b0), .DataWidth(DW), .NumReadPorts(NP), .WriteForward(1'b1)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
        .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
        .pend_set_i(pend_set), .pend_addr_i(pend_addr),
        .clear_req_i(clear_req), .clear_busy_o(clear_busy)
    );

    ibex_register_file_mp #(
        .RV32E(1'b1), .DataWidth(DW), .NumReadPorts(NPE), .WriteForward(1'b1)
    ) dut_e (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .raddr_i(e_raddr), .rdata_o(e_rdata), .rbusy_o(e_rbusy),
        .waddr_a_i(e_waddr_a), .wdata_a_i(e_wdata_a), .we_a_i(e_we_a),
        .waddr_b_i(e_waddr_b), .wdata_b_i(e_wdata_b), .we_b_i(e_we_b),
        .pend_set_i(e_pend_set), .pend_addr_i(e_pend_addr),
        .clear_req_i(e_clear_req), .clear_busy_o(e_clear_busy)
    );

    always #5 clk_i = ~clk_i;

    typedef enum int {K_DATA, K_BUSY, K_CLR} kind_e;
    typedef struct {
        string       name;
        bit          rv32e;
        int          port;
        kind_e       kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        exp_t        e;
        logic [31:0] act;
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                K_DATA:  act = e.rv32e ? e_rdata[DW*e.port +: DW] : rdata[DW*e.port +: DW];
                K_BUSY:  act = {31'b0, (e.rv32e ? e_rbusy[e.port] : rbusy[e.port])};
                default: act = {31'b0, (e.rv32e ? e_clear_busy : clear_busy)};
            endcase
            check(e.name, act, e.exp);
        end
    end

    function automatic void push(input string n, input bit rv, input int port, input kind_e k,
                                 input logic [31:0] v);
        exp_t e;
        e.name  = n;
        e.rv32e = rv;
        e.port  = port;
        e.kind  = k;
        e.exp   = v;
        sb_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_in();
        we_a = 1'b0; we_b = 1'b0; pend_set = 1'b0; clear_req = 1'b0;
        e_we_a = 1'b0; e_we_b = 1'b0; e_pend_set = 1'b0; e_clear_req = 1'b0;
    endtask

    task automatic wr_a(input int a, input logic [31:0] d);
        waddr_a = 5'(a); wdata_a = d; we_a = 1'b1;
    endtask

    task automatic wr_b(input int a, input logic [31:0] d);
        waddr_b = 5'(a); wdata_b = d; we_b = 1'b1;
    endtask

    task automatic pset(input int a);
        pend_addr = 5'(a); pend_set = 1'b1;
    endtask

    task automatic exp_rd(input string n, input int port, input int a, input logic [31:0] d,
                          input logic b);
        raddr[5*port +: 5] = 5'(a);
        push({n, "_data"}, 1'b0, port, K_DATA, d);
        push({n, "_busy"}, 1'b0, port, K_BUSY, {31'b0, b});
    endtask

    task automatic e_exp_rd(input string n, input int port, input int a, input logic [31:0] d,
                            input logic b);
        e_raddr[5*port +: 5] = 5'(a);
        push({n, "_data"}, 1'b1, port, K_DATA, d);
        push({n, "_busy"}, 1'b1, port, K_BUSY, {31'b0, b});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0;
        idle_in();
        raddr = '0; waddr_a = '0; waddr_b = '0; wdata_a = '0; wdata_b = '0; pend_addr = '0;
        e_raddr = '0; e_waddr_a = '0; e_waddr_b = '0; e_wdata_a = '0; e_wdata_b = '0;
        e_pend_addr = '0;
        #12 rst_ni = 1'b1;
        tick();

        idle_in();
        for (int p = 0; p < NP; p++) exp_rd("reset_x5", p, 5, 32'h0, 1'b0);
        push("reset_clr_busy", 1'b0, 0, K_CLR, 32'd0);
        tick();

        idle_in(); wr_a(5, 32'hDEADBEEF); exp_rd("fwd_x5", 0, 5, 32'hDEADBEEF, 1'b0); tick();
        idle_in();
        for (int p = 0; p < NP; p++) exp_rd("rd_x5", p, 5, 32'hDEADBEEF, 1'b0);
        tick();

        idle_in(); wr_a(7, 32'h1111); wr_b(7, 32'h2222);
        exp_rd("ab_fwd_x7", 0, 7, 32'h1111, 1'b0); tick();
        idle_in(); exp_rd("ab_x7", 1, 7, 32'h1111, 1'b0); tick();

        idle_in(); pset(9); exp_rd("pset_same_x9", 0, 9, 32'h0, 1'b0); tick();
        idle_in(); exp_rd("busy_x9", 0, 9, 32'h0, 1'b1); exp_rd("busy_x9_p2", 2, 9, 32'h0, 1'b1);
        tick();
        idle_in(); wr_b(9, 32'h55); exp_rd("ldfwd_x9", 0, 9, 32'h55, 1'b0); tick();
        idle_in(); exp_rd("ld_x9", 0, 9, 32'h55, 1'b0); tick();

        idle_in(); pset(3); wr_b(3, 32'h33); tick();
        idle_in(); exp_rd("setwins_x3", 0, 3, 32'h33, 1'b1); tick();

        idle_in(); pset(11); tick();
        idle_in(); wr_a(11, 32'hA); wr_b(11, 32'hB); exp_rd("awin_fwd_x11", 0, 11, 32'hA, 1'b0);
        tick();
        idle_in(); exp_rd("awin_x11", 0, 11, 32'hA, 1'b0); tick();

        idle_in(); wr_a(0, 32'hFFFF); pset(0); exp_rd("x0_fwd", 0, 0, 32'h0, 1'b0); tick();
        idle_in(); exp_rd("x0", 0, 0, 32'h0, 1'b0); tick();

        for (int i = 1; i < 32; i++) begin
            idle_in(); wr_a(i, 32'(32'h100 + i)); tick();
        end
        idle_in(); pset(12); tick();
        idle_in();
        exp_rd("fill_x31", 0, 31, 32'h11F, 1'b0);
        exp_rd("pend_x12", 1, 12, 32'h10C, 1'b1);
        exp_rd("fill_x1", 2, 1, 32'h101, 1'b0);
        tick();

        idle_in(); clear_req = 1'b1; push("clr_start", 1'b0, 0, K_CLR, 32'd0); tick();
        for (int k = 0; k < 32; k++) begin
            idle_in();
            push($sformatf("clr_busy_k%0d", k), 1'b0, 0, K_CLR, (k < 31) ? 32'd1 : 32'd0);
            if (k == 0) exp_rd("clr_pend_x12", 0, 12, 32'h10C, 1'b0);
            if (k == 10) begin
                exp_rd("clr_partial_x20", 0, 20, 32'h114, 1'b0);
                exp_rd("clr_done_x2", 1, 2, 32'h0, 1'b0);
            end
            if (k == 20) begin
                wr_a(5, 32'hBAD); wr_b(6, 32'hBAD); pset(7);
                exp_rd("clr_nofwd_x5", 0, 5, 32'h0, 1'b0);
            end
            if (k == 30) clear_req = 1'b1;
            tick();
        end
        idle_in();
        exp_rd("post_x5", 0, 5, 32'h0, 1'b0);
        exp_rd("post_x6", 1, 6, 32'h0, 1'b0);
        exp_rd("post_x7", 2, 7, 32'h0, 1'b0);
        push("post_clr_busy", 1'b0, 0, K_CLR, 32'd0);
        tick();
        idle_in();
        exp_rd("post_x31", 0, 31, 32'h0, 1'b0);
        exp_rd("post_x1", 1, 1, 32'h0, 1'b0);
        exp_rd("post_x12", 2, 12, 32'h0, 1'b0);
        tick();
        idle_in(); wr_a(8, 32'h88); tick();
        idle_in(); exp_rd("post_wr_x8", 0, 8, 32'h88, 1'b0); tick();

        idle_in(); wr_a(4, 32'h44); tick();
        idle_in(); clear_req = 1'b1; tick();
        idle_in(); tick();
        idle_in(); tick();
        idle_in(); exp_rd("preclr_x4", 0, 4, 32'h44, 1'b0);
        push("mid_clr_busy", 1'b0, 0, K_CLR, 32'd1);
        tick();
        rst_ni = 1'b0;
        idle_in();
        exp_rd("rst_x4", 0, 4, 32'h0, 1'b0);
        exp_rd("rst_x8", 1, 8, 32'h0, 1'b0);
        push("rst_clr_busy", 1'b0, 0, K_CLR, 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        idle_in(); push("after_rst_clr_busy", 1'b0, 0, K_CLR, 32'd0); tick();

        idle_in(); e_waddr_a = 5'd4; e_wdata_a = 32'h4; e_we_a = 1'b1; tick();
        idle_in(); e_waddr_a = 5'd20; e_wdata_a = 32'hABCD; e_we_a = 1'b1;
        e_exp_rd("e_fwd_x20", 0, 20, 32'h0, 1'b0); tick();
        idle_in(); e_pend_addr = 5'd20; e_pend_set = 1'b1; tick();
        idle_in();
        e_exp_rd("e_x20", 0, 20, 32'h0, 1'b0);
        e_exp_rd("e_x4", 1, 4, 32'h4, 1'b0);
        tick();
        idle_in(); e_clear_req = 1'b1; push("e_clr_start", 1'b1, 0, K_CLR, 32'd0); tick();
        for (int k = 0; k < 16; k++) begin
            idle_in();
            push($sformatf("e_clr_busy_k%0d", k), 1'b1, 0, K_CLR, (k < 15) ? 32'd1 : 32'd0);
            tick();
        end
        idle_in(); e_exp_rd("e_post_x4", 0, 4, 32'h0, 1'b0); tick();

        idle_in();
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
